// File: rtl/rca16_sum_accumulator.sv
// Block-sum accumulator behind the 16-bit ripple-carry adder: sums COUNT samples, then holds the total.
// Define RCA16_SUM_ACCUMULATOR_SATURATE_EN to clamp on overflow instead of wrapping.
module rca16_sum_accumulator #(
    parameter int IN_W  = 17,
    parameter int ACC_W = 24,
    parameter int COUNT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_sum,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_ovf,
    output logic             busy
);

    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;

    typedef enum logic {
        ST_ACC,
        ST_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] out_acc_q, out_acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;

    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] sum_next;
    logic             carry;
    logic             xfer_in;
    logic             xfer_out;
    logic             last;

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_HOLD);
    assign out_acc   = out_acc_q;
    assign out_ovf   = ovf_q;
    assign busy      = busy_q;

    assign xfer_in  = in_valid & in_ready;
    assign xfer_out = out_valid & out_ready;
    assign last     = (cnt_q == CNT_W'(COUNT - 1));

    always_comb begin
        sum_wide = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, in_sum};
        carry    = sum_wide[ACC_W];
`ifdef RCA16_SUM_ACCUMULATOR_SATURATE_EN
        // once clamped, the block stays at all-ones until handed off
        sum_next = (carry || ovf_q) ? '1 : sum_wide[ACC_W-1:0];
`else
        sum_next = sum_wide[ACC_W-1:0];
`endif
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        out_acc_d = out_acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        busy_d    = busy_q;
        unique case (state_q)
            ST_ACC: begin
                if (xfer_in) begin
                    acc_d  = sum_next;
                    ovf_d  = ovf_q | carry;
                    busy_d = 1'b1;
                    if (last) begin
                        cnt_d     = '0;
                        out_acc_d = sum_next;
                        state_d   = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (xfer_out) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_ACC;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ACC;
            acc_q     <= '0;
            out_acc_q <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            out_acc_q <= out_acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_rca16_sum_accumulator.sv
// Self-checking bench for rca16_sum_accumulator: default, ACC_W=20 and COUNT=1 instances.
module tb_rca16_sum_accumulator;

    localparam int    ACC_W = 24;
    localparam int    COUNT = 16;
    localparam longint LIM  = longint'(1) << ACC_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [16:0] in_sum;
    logic        in_valid, in_ready, out_valid, out_ready, out_ovf, busy;
    logic [23:0] out_acc;

    logic [16:0] w_in_sum;
    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_ovf, w_busy;
    logic [19:0] w_out_acc;

    logic [16:0] c_in_sum;
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_ovf, c_busy;
    logic [23:0] c_out_acc;

    rca16_sum_accumulator u_dut (
        .clk(clk), .rst(rst), .in_sum(in_sum), .in_valid(in_valid),
        .in_ready(in_ready), .out_acc(out_acc), .out_valid(out_valid),
        .out_ready(out_ready), .out_ovf(out_ovf), .busy(busy)
    );

    rca16_sum_accumulator #(.ACC_W(20)) u_w20 (
        .clk(clk), .rst(rst), .in_sum(w_in_sum), .in_valid(w_in_valid),
        .in_ready(w_in_ready), .out_acc(w_out_acc), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .out_ovf(w_out_ovf), .busy(w_busy)
    );

    rca16_sum_accumulator #(.COUNT(1)) u_c1 (
        .clk(clk), .rst(rst), .in_sum(c_in_sum), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .out_acc(c_out_acc), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_ovf(c_out_ovf), .busy(c_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the block total is the plain sum of its accepted samples.
    longint m_sum;
    int     m_n;
    bit     m_pend;
    longint m_acc;
    bit     m_povf;
    int     lowcnt;
    logic [16:0] c_q[$];
    int     c_pops = 0;
    bit     c_rand = 1'b0;

    function automatic longint fin(input longint s);
`ifdef RCA16_SUM_ACCUMULATOR_SATURATE_EN
        return (s >= LIM) ? LIM - 1 : s;
`else
        return s % LIM;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_out_acc", out_acc, 0);
            chk("rst_out_ovf", out_ovf, 0);
            m_sum  = 0;
            m_n    = 0;
            m_pend = 0;
            m_acc  = 0;
            m_povf = 0;
            c_q.delete();
        end else begin
            chk("in_ready", in_ready, !m_pend);
            chk("out_valid", out_valid, m_pend);
            chk("busy", busy, m_pend || m_n > 0);
            chk("out_acc", out_acc, m_acc);
            chk("out_ovf", out_ovf, m_pend ? m_povf : (m_sum >= LIM));
            if (!in_ready) lowcnt++;
            if (m_pend) begin
                if (out_ready) begin
                    m_pend = 0;
                    m_sum  = 0;
                    m_n    = 0;
                end
            end else if (in_valid) begin
                m_sum += longint'(in_sum);
                m_n++;
                if (m_n == COUNT) begin
                    m_pend = 1;
                    m_acc  = fin(m_sum);
                    m_povf = (m_sum >= LIM);
                end
            end
            if (c_out_valid && c_out_ready) begin
                if (c_q.size() == 0) chk("c1_pending", c_q.size(), 1);
                else chk("c1_out_acc", c_out_acc, c_q.pop_front());
                c_pops++;
            end
            if (c_in_valid && c_in_ready) c_q.push_back(c_in_sum);
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (c_rand) c_out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [16:0] v);
        logic r;
        r = 1'b0;
        in_valid = 1'b1;
        in_sum   = v;
        for (int k = 0; k < 100 && !r; k++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
        end
        if (!r) chk("send_accept", r, 1);
    endtask

    task automatic wait_valid();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        chk("wait_valid", out_valid, 1);
    endtask

    initial begin
        logic [16:0] cvals[8];
        logic        r;
        cvals = '{17'h00001, 17'h1FFFE, 17'h00000, 17'h01234,
                  17'h0ABCD, 17'h10000, 17'h000FF, 17'h1FFFF};
        rst = 1'b1;
        in_valid = 0; in_sum = 0; out_ready = 1;
        w_in_valid = 0; w_in_sum = 0; w_out_ready = 1;
        c_in_valid = 0; c_in_sum = 0; c_out_ready = 1;
        lowcnt = 0;
        @(negedge clk);
        chk("reset_out_acc", out_acc, 0);
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;

        lowcnt = 0;
        for (int i = 1; i <= 16; i++) send(17'(i));
        in_valid = 0;
        wait_valid();
        chk("t1_acc", out_acc, 136);
        chk("t1_ovf", out_ovf, 0);
        chk("t1_model_pin", m_acc, 136);
        repeat (3) @(negedge clk);
        chk("t1_ready_low_cycles", lowcnt, 1);
        @(posedge clk);
        #1;

        repeat (16) send(17'h1FFFE);
        in_valid = 0;
        wait_valid();
        chk("t2_acc", out_acc, 64'h1FFFE0);
        chk("t2_ovf", out_ovf, 0);
        @(posedge clk);
        #1;

        out_ready = 0;
        repeat (16) send(17'd1);
        in_sum = 17'd7;
        wait_valid();
        repeat (5) begin
            chk("t3_hold_acc", out_acc, 16);
            chk("t3_hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1;
        send(17'd7);
        repeat (15) send(17'd0);
        in_valid = 0;
        wait_valid();
        chk("t3_next_first", out_acc, 7);
        @(posedge clk);
        #1;

        repeat (7) send(17'h100);
        in_sum = 17'h100;
        in_valid = 1;
        rst = 1;
        @(negedge clk);
        chk("t4_rst_valid", out_valid, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_acc", out_acc, 0);
        chk("t4_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1 rst = 0;
        in_valid = 0;
        repeat (16) send(17'd2);
        in_valid = 0;
        wait_valid();
        chk("t4_acc", out_acc, 32);

        @(posedge clk);
        #1 w_in_valid = 1;
        w_in_sum = 17'h1FFFE;
        repeat (16) @(posedge clk);
        #1 w_in_valid = 0;
        r = 1'b0;
        for (int k = 0; k < 20 && !r; k++) begin
            @(negedge clk);
            r = w_out_valid;
        end
        chk("w20_valid", w_out_valid, 1);
`ifdef RCA16_SUM_ACCUMULATOR_SATURATE_EN
        chk("w20_acc", w_out_acc, 64'hFFFFF);
`else
        chk("w20_acc", w_out_acc, 64'hFFFE0);
`endif
        chk("w20_ovf", w_out_ovf, 1);
        @(posedge clk);
        #1 c_rand = 1;

        foreach (cvals[j]) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            c_in_valid = 1;
            c_in_sum   = cvals[j];
            r = 1'b0;
            for (int k = 0; k < 200 && !r; k++) begin
                @(negedge clk);
                r = c_in_ready;
                @(posedge clk);
                #1;
            end
            if (!r) chk("c1_accept", r, 1);
            c_in_valid = 0;
        end
        c_rand = 0;
        c_out_ready = 1;
        repeat (5) @(negedge clk);
        chk("c1_count", c_pops, 8);
        chk("c1_drained", c_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
